// File: rtl/step_motor_sequencer.sv
// rtl/step_motor_sequencer.sv - trapezoidal step/dir pulse sequencer with register-mapped control
module step_motor_sequencer #(
    parameter int PULSE_W   = 4,
    parameter int DIR_SETUP = 8
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_ctrl_address,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy,
    output logic        irq
);

    localparam logic [31:0] PW_M1    = 32'(PULSE_W - 1);
    localparam logic [31:0] PW2      = 32'(2 * PULSE_W);
    localparam logic [31:0] SETUP_M1 = 32'(DIR_SETUP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCEL, CRUISE, DECEL} state_t;
    state_t state, state_nx, ramp_state;

    logic [31:0] target, period_start, period_min, accel_dec, position;
    logic        done, aborted, abort_pend;
    logic [31:0] remaining, period, pstart_w, pmin_w, accel_w, ramp;
    logic [31:0] scnt, tcnt, pcnt;

    logic        wr_ctrl, start_req, abort_req, stopping, pulse_done;
    logic        fire, finish, do_start;
    logic [31:0] rem_nx, period_nx, ramp_nx, period_up, period_dn;
    logic [32:0] sum_ext, floor_ext;
    logic [31:0] min_clip, eff_start, eff_min;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old_v[i*8 +: 8];
        return res;
    endfunction

    assign avs_ctrl_waitrequest = 1'b0;
    assign busy = (state != IDLE);
    assign irq  = done;

    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 3'd4) && avs_ctrl_byteenable[0];
    assign start_req = wr_ctrl && avs_ctrl_writedata[0];
    assign abort_req = wr_ctrl && avs_ctrl_writedata[2];

    // Clip MIN to START first, then floor both so a period always fits one pulse plus an equal low time.
    assign min_clip  = (period_min > period_start) ? period_start : period_min;
    assign eff_start = (period_start < PW2) ? PW2 : period_start;
    assign eff_min   = (min_clip < PW2) ? PW2 : min_clip;

    assign stopping   = abort_pend || abort_req || (remaining == 32'd0);
    assign pulse_done = !step_out || (pcnt == 32'd0);

    always_comb begin
        rem_nx     = remaining - 32'd1;
        sum_ext    = {1'b0, period} + {1'b0, accel_w};
        floor_ext  = {1'b0, pmin_w} + {1'b0, accel_w};
        period_up  = (sum_ext > {1'b0, pstart_w}) ? pstart_w : sum_ext[31:0];
        period_dn  = ({1'b0, period} < floor_ext) ? pmin_w : period - accel_w;
        period_nx  = period;
        ramp_nx    = ramp;
        ramp_state = CRUISE;
        if (rem_nx <= ramp) begin
            ramp_state = DECEL;
            period_nx  = period_up;
            ramp_nx    = (ramp == 32'd0) ? 32'd0 : ramp - 32'd1;
        end else if (period > pmin_w) begin
            ramp_state = ACCEL;
            period_nx  = period_dn;
            ramp_nx    = ramp + 32'd1;
        end
    end

    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        finish   = 1'b0;
        do_start = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    do_start = 1'b1;
                    if (avs_ctrl_address == 3'd4 && target != 32'd0)
                        state_nx = SETUP;
                end
            end
            SETUP: begin
                if (abort_req || abort_pend) finish = 1'b1;
                else if (scnt == 32'd0)      fire   = 1'b1;
            end
            default: begin
                if (stopping) finish = pulse_done;
                else if (tcnt == 32'd0) fire = 1'b1;
            end
        endcase
        if (fire)   state_nx = ramp_state;
        if (finish) state_nx = IDLE;
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) state <= IDLE;
        else                state <= state_nx;
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            target <= '0; period_start <= '0; period_min <= '0; accel_dec <= '0;
            position <= '0; done <= 1'b0; aborted <= 1'b0; abort_pend <= 1'b0;
            remaining <= '0; period <= '0; pstart_w <= '0; pmin_w <= '0;
            accel_w <= '0; ramp <= '0; scnt <= '0; tcnt <= '0; pcnt <= '0;
            step_out <= 1'b0; dir_out <= 1'b0; avs_ctrl_readdata <= '0;
        end else begin
            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    3'd0: target       <= be_merge(target, avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd1: period_start <= be_merge(period_start, avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd2: period_min   <= be_merge(period_min, avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd3: accel_dec    <= be_merge(accel_dec, avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd5: if (avs_ctrl_byteenable[0]) begin
                        if (avs_ctrl_writedata[1]) done    <= 1'b0;
                        if (avs_ctrl_writedata[2]) aborted <= 1'b0;
                    end
                    3'd6: if (state == IDLE)
                        position <= be_merge(position, avs_ctrl_writedata, avs_ctrl_byteenable);
                    default: ;
                endcase
            end

            if (do_start) begin
                remaining  <= target;
                period     <= eff_start;
                pstart_w   <= eff_start;
                pmin_w     <= eff_min;
                accel_w    <= accel_dec;
                dir_out    <= avs_ctrl_writedata[1];
                ramp       <= '0;
                scnt       <= SETUP_M1;
                aborted    <= 1'b0;
                abort_pend <= 1'b0;
                done       <= (target == 32'd0);
            end

            if (state == SETUP && scnt != 32'd0) scnt <= scnt - 32'd1;
            if (state != IDLE && state != SETUP && tcnt != 32'd0) tcnt <= tcnt - 32'd1;
            if (step_out) begin
                if (pcnt == 32'd0) step_out <= 1'b0;
                else               pcnt     <= pcnt - 32'd1;
            end

            // The timer reloads with the pre-update period so spacing follows the period at the earlier edge.
            if (fire) begin
                step_out  <= 1'b1;
                pcnt      <= PW_M1;
                tcnt      <= period - 32'd1;
                remaining <= rem_nx;
                position  <= dir_out ? position + 32'd1 : position - 32'd1;
                period    <= period_nx;
                ramp      <= ramp_nx;
            end

            if (abort_req && state != IDLE) abort_pend <= 1'b1;

            if (finish) begin
                done       <= 1'b1;
                aborted    <= abort_pend || abort_req;
                abort_pend <= 1'b0;
            end

            if (avs_ctrl_read) begin
                case (avs_ctrl_address)
                    3'd0:    avs_ctrl_readdata <= target;
                    3'd1:    avs_ctrl_readdata <= period_start;
                    3'd2:    avs_ctrl_readdata <= period_min;
                    3'd3:    avs_ctrl_readdata <= accel_dec;
                    3'd5:    avs_ctrl_readdata <= {29'd0, aborted, done, busy};
                    3'd6:    avs_ctrl_readdata <= position;
                    default: avs_ctrl_readdata <= '0;
                endcase
            end
        end
    end

endmodule
